ntt_data_frame: RTL and testbench

NTT_DATA_FRAME -- requirements
Module: ntt_data_frame

---
 rtl/ntt_data_frame.sv | 99 +++++++++
 tb/tb_ntt_data_frame.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_data_frame.sv
// Frame buffer for NTT/INTT coefficient streams: collects up to FRAME_LEN words,
// then drains them in bit-reversed (full NTT frame) or natural order.
`timescale 1ns/1ps
module ntt_data_frame #(
  parameter int FRAME_LEN = 256,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] S_AXIS_tdata,
  input  logic              S_AXIS_tvalid,
  input  logic              S_AXIS_tlast,
  output logic              S_AXIS_tready,
  input  logic              NTT_INTT_sel,
  output logic [DATA_W-1:0] M_AXIS_tdata,
  output logic              M_AXIS_tvalid,
  output logic              M_AXIS_tlast,
  input  logic              M_AXIS_tready,
  output logic [7:0]        NTT_counter
);
  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [0:0] S_LOAD  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  logic [DATA_W-1:0] frame_buf [FRAME_LEN];
  logic [0:0]        state;
  logic [AW-1:0]     wr_cnt, rd_cnt, rd_rev, rd_addr, last_idx;
  logic              sel_q, issued_all;
  logic              s_hs, close_hs, final_hs, out_load;

  assign s_hs     = S_AXIS_tvalid & S_AXIS_tready;
  assign close_hs = s_hs & (S_AXIS_tlast | (wr_cnt == LAST_IDX));
  assign final_hs = M_AXIS_tvalid & M_AXIS_tready & M_AXIS_tlast;
  // Output register refills whenever empty or being consumed, so a ready sink sees no bubbles.
  assign out_load = (state == S_DRAIN) & ~issued_all & (~M_AXIS_tvalid | M_AXIS_tready);

  always_comb begin
    rd_rev = '0;
    for (int i = 0; i < AW; i++) rd_rev[i] = rd_cnt[AW-1-i];
  end

  // Bit-reversed order only applies to a full-length NTT frame.
  assign rd_addr = (sel_q && last_idx == LAST_IDX) ? rd_rev : rd_cnt;

  always_ff @(posedge clk) begin
    if (s_hs) frame_buf[wr_cnt] <= S_AXIS_tdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_LOAD;
      S_AXIS_tready <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      last_idx      <= '0;
      sel_q         <= 1'b0;
      issued_all    <= 1'b0;
      M_AXIS_tdata  <= '0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tlast  <= 1'b0;
      NTT_counter   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          S_AXIS_tready <= 1'b1;
          if (s_hs) begin
            if (wr_cnt == '0) sel_q <= NTT_INTT_sel;
            if (close_hs) begin
              last_idx      <= wr_cnt;
              state         <= S_DRAIN;
              S_AXIS_tready <= 1'b0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        default: begin
          if (out_load) begin
            M_AXIS_tdata  <= frame_buf[rd_addr];
            M_AXIS_tlast  <= (rd_cnt == last_idx);
            M_AXIS_tvalid <= 1'b1;
            if (rd_cnt == last_idx) issued_all <= 1'b1;
            else                    rd_cnt     <= rd_cnt + 1'b1;
          end else if (final_hs) begin
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
            NTT_counter   <= NTT_counter + 1'b1;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            issued_all    <= 1'b0;
            state         <= S_LOAD;
            S_AXIS_tready <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_data_frame.sv
// Directed bench for ntt_data_frame: order, framing, backpressure and reset behaviour.
`timescale 1ns/1ps
module tb_ntt_data_frame;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, sel_in = 1'b0, m_ready = 1'b0;
  logic        s_ready, m_valid, m_last;
  logic [31:0] m_data;
  logic [7:0]  cnt;

  int checks = 0, failures = 0;
  int cyc = 0, rmode = 0;
  int stab_err = 0, sready_err = 0;
  bit prev_stall = 1'b0;
  logic [31:0] held_d = '0;
  logic        held_l = 1'b0;
  logic [31:0] rx_d[$];
  bit          rx_l[$];
  int          rx_c[$];

  ntt_data_frame #(.FRAME_LEN(256), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .S_AXIS_tdata(s_data), .S_AXIS_tvalid(s_valid), .S_AXIS_tlast(s_last),
    .S_AXIS_tready(s_ready), .NTT_INTT_sel(sel_in),
    .M_AXIS_tdata(m_data), .M_AXIS_tvalid(m_valid), .M_AXIS_tlast(m_last),
    .M_AXIS_tready(m_ready), .NTT_counter(cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready pattern: 0 = always, 1 = random, 2 = 4-cycle toggle plus random.
  always begin
    @(posedge clk); #1;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = cyc[2] ? 1'b1 : ($urandom_range(0, 3) == 0);
    endcase
  end

  // Inputs settle at posedge+1, so the negedge view is what the next edge will see.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!m_valid || m_data !== held_d || m_last !== held_l))
        stab_err <= stab_err + 1;
      if (m_valid && s_ready) sready_err <= sready_err + 1;
      prev_stall <= m_valid && !m_ready;
      held_d     <= m_data;
      held_l     <= m_last;
      if (m_valid && m_ready) begin
        rx_d.push_back(m_data);
        rx_l.push_back(m_last);
        rx_c.push_back(cyc);
      end
    end
  end

  function automatic logic [7:0] bitrev8(input logic [7:0] k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = k[7-i];
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Sends n words base+k; sel is offered on word 0 and inverted afterwards.
  task automatic send(input int n, input logic [31:0] base, input int last_idx,
                      input bit sel, input int idle_pct, output int close_cyc);
    bit rdy;
    int t;
    close_cyc = 0;
    for (int k = 0; k < n; k++) begin
      while (idle_pct > 0 && int'($urandom_range(0, 99)) < idle_pct) begin
        s_valid = 1'b0; @(posedge clk); #1;
      end
      s_valid = 1'b1; s_data = base + 32'(k); s_last = (k == last_idx);
      sel_in = (k == 0) ? sel : ~sel;
      t = 0;
      do begin
        @(negedge clk); rdy = s_ready;
        @(posedge clk); #1; t++;
      end while (!rdy && t < 3000);
      if (!rdy) begin
        checks++; failures++;
        $display("FAIL send_timeout word=%0d got tready=0 want 1", k);
        break;
      end
      close_cyc = cyc;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int t = 0;
    while (rx_d.size() < target && t < 5000) begin @(posedge clk); t++; end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    checks += 5;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_tready got %b want 0", s_ready); end
    if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got %b want 0", m_valid); end
    if (m_last !== 1'b0) begin failures++; $display("FAIL rst_tlast got %b want 0", m_last); end
    if (m_data !== 32'h0) begin failures++; $display("FAIL rst_tdata got %h want 0", m_data); end
    if (cnt !== 8'h0) begin failures++; $display("FAIL rst_counter got %0d want 0", cnt); end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL rel_tready_pre got %b want 0", s_ready); end
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL rel_tready_post got %b want 1", s_ready); end
  endtask

  task automatic test_ntt_bitrev();
    int b, cc, gaps;
    do_reset(); rmode = 0; b = rx_d.size();
    send(256, 32'h0, -1, 1'b1, 0, cc);
    wait_rx(b + 256);
    checks++;
    if (rx_d.size() != b + 256) begin
      failures++; $display("FAIL ntt_count got %0d want 256", rx_d.size() - b);
    end else begin
      gaps = 0;
      for (int k = 0; k < 256; k++) begin
        checks++;
        if (rx_d[b+k] !== {24'h0, bitrev8(8'(k))} || rx_l[b+k] !== (k == 255)) begin
          failures++;
          $display("FAIL ntt_word k=%0d got %h/%b want %h/%b", k, rx_d[b+k], rx_l[b+k], bitrev8(8'(k)), k == 255);
        end
        if (k > 0 && rx_c[b+k] != rx_c[b+k-1] + 1) gaps++;
      end
      checks += 2;
      if (gaps != 0) begin failures++; $display("FAIL ntt_bubbles got %0d want 0", gaps); end
      if (rx_c[b] - cc > 2 || rx_c[b] - cc < 1) begin
        failures++; $display("FAIL ntt_latency got %0d want 1..2", rx_c[b] - cc);
      end
    end
    checks++;
    if (cnt !== 8'd1) begin failures++; $display("FAIL ntt_counter got %0d want 1", cnt); end
  endtask

  task automatic test_intt_natural();
    int b, cc, gaps, e0;
    do_reset(); rmode = 0; b = rx_d.size(); e0 = sready_err;
    send(256, 32'h0, -1, 1'b0, 0, cc);
    wait_rx(b + 256);
    checks++;
    if (rx_d.size() != b + 256) begin
      failures++; $display("FAIL intt_count got %0d want 256", rx_d.size() - b);
    end else begin
      gaps = 0;
      for (int k = 0; k < 256; k++) begin
        checks++;
        if (rx_d[b+k] !== 32'(k) || rx_l[b+k] !== (k == 255)) begin
          failures++;
          $display("FAIL intt_word k=%0d got %h/%b want %h/%b", k, rx_d[b+k], rx_l[b+k], k, k == 255);
        end
        if (k > 0 && rx_c[b+k] != rx_c[b+k-1] + 1) gaps++;
      end
      checks++;
      if (gaps != 0) begin failures++; $display("FAIL intt_bubbles got %0d want 0", gaps); end
    end
    checks += 2;
    if (sready_err != e0) begin failures++; $display("FAIL intt_tready_in_drain got %0d want 0", sready_err - e0); end
    if (cnt !== 8'd1) begin failures++; $display("FAIL intt_counter got %0d want 1", cnt); end
  endtask

  task automatic test_short_frame();
    int b, cc;
    do_reset(); rmode = 0; b = rx_d.size();
    send(10, 32'h0, 9, 1'b1, 0, cc);
    wait_rx(b + 10);
    checks++;
    if (rx_d.size() != b + 10) begin
      failures++; $display("FAIL short_count got %0d want 10", rx_d.size() - b);
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (rx_d[b+k] !== 32'(k) || rx_l[b+k] !== (k == 9)) begin
          failures++;
          $display("FAIL short_word k=%0d got %h/%b want %h/%b", k, rx_d[b+k], rx_l[b+k], k, k == 9);
        end
      end
    end
    checks++;
    if (cnt !== 8'd1) begin failures++; $display("FAIL short_counter got %0d want 1", cnt); end
  endtask

  task automatic test_back_to_back();
    int b, cc, s0;
    logic [31:0] exp_d;
    bit exp_l;
    do_reset(); rmode = 1; b = rx_d.size(); s0 = stab_err;
    send(257, 32'h0, 256, 1'b0, 30, cc);
    wait_rx(b + 257);
    repeat (10) @(posedge clk); #1;
    checks++;
    if (rx_d.size() != b + 257) begin
      failures++; $display("FAIL b2b_count got %0d want 257", rx_d.size() - b);
    end else begin
      for (int k = 0; k < 257; k++) begin
        exp_d = 32'(k);
        exp_l = (k == 255) || (k == 256);
        checks++;
        if (rx_d[b+k] !== exp_d || rx_l[b+k] !== exp_l) begin
          failures++;
          $display("FAIL b2b_word k=%0d got %h/%b want %h/%b", k, rx_d[b+k], rx_l[b+k], exp_d, exp_l);
        end
      end
    end
    checks += 2;
    if (cnt !== 8'd2) begin failures++; $display("FAIL b2b_counter got %0d want 2", cnt); end
    if (stab_err != s0) begin failures++; $display("FAIL b2b_stable got %0d want 0", stab_err - s0); end
    rmode = 0;
  endtask

  task automatic test_backpressure();
    int b, cc, s0;
    do_reset(); rmode = 2; b = rx_d.size(); s0 = stab_err;
    send(256, 32'h1000, 255, 1'b1, 0, cc);
    wait_rx(b + 256);
    repeat (20) @(posedge clk); #1;
    checks++;
    if (rx_d.size() != b + 256) begin
      failures++; $display("FAIL bp_count got %0d want 256", rx_d.size() - b);
    end else begin
      for (int k = 0; k < 256; k++) begin
        checks++;
        if (rx_d[b+k] !== 32'h1000 + {24'h0, bitrev8(8'(k))} || rx_l[b+k] !== (k == 255)) begin
          failures++;
          $display("FAIL bp_word k=%0d got %h/%b want %h/%b", k, rx_d[b+k], rx_l[b+k],
                   32'h1000 + {24'h0, bitrev8(8'(k))}, k == 255);
        end
      end
    end
    checks += 3;
    if (stab_err != s0) begin failures++; $display("FAIL bp_stable got %0d want 0", stab_err - s0); end
    if (cnt !== 8'd1) begin failures++; $display("FAIL bp_counter got %0d want 1", cnt); end
    if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_tready_after got %b want 1", s_ready); end
    rmode = 0;
  endtask

  task automatic test_reset_mid_drain();
    int b, cc, t;
    do_reset(); rmode = 0; b = rx_d.size();
    send(256, 32'h0, -1, 1'b0, 0, cc);
    t = 0;
    while (rx_d.size() < b + 100 && t < 2000) begin @(posedge clk); #1; t++; end
    checks++;
    if (rx_d.size() < b + 100) begin failures++; $display("FAIL mid_reach100 got %0d want 100", rx_d.size() - b); end
    reset = 1'b1; #1;
    checks += 5;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_tvalid got %b want 0", m_valid); end
    if (m_last !== 1'b0) begin failures++; $display("FAIL mid_tlast got %b want 0", m_last); end
    if (m_data !== 32'h0) begin failures++; $display("FAIL mid_tdata got %h want 0", m_data); end
    if (cnt !== 8'h0) begin failures++; $display("FAIL mid_counter got %0d want 0", cnt); end
    if (s_ready !== 1'b0) begin failures++; $display("FAIL mid_tready got %b want 0", s_ready); end
    do_reset();
    b = rx_d.size();
    send(256, 32'h2000, -1, 1'b0, 0, cc);
    wait_rx(b + 256);
    checks++;
    if (rx_d.size() != b + 256) begin
      failures++; $display("FAIL post_count got %0d want 256", rx_d.size() - b);
    end else begin
      for (int k = 0; k < 256; k++) begin
        checks++;
        if (rx_d[b+k] !== 32'h2000 + 32'(k) || rx_l[b+k] !== (k == 255)) begin
          failures++;
          $display("FAIL post_word k=%0d got %h/%b want %h/%b", k, rx_d[b+k], rx_l[b+k], 32'h2000 + 32'(k), k == 255);
        end
      end
    end
    checks++;
    if (cnt !== 8'd1) begin failures++; $display("FAIL post_counter got %0d want 1", cnt); end
  endtask

  initial begin
    test_reset();
    test_ntt_bitrev();
    test_intt_natural();
    test_short_frame();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
